// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and flush controller for a 3-stage IF / ID / EX-WB pipeline.
// It stalls the PC and the IF/ID buffer on read-after-write hazards.
// It squashes wrong-path work after a branch that resolves taken in WB.
// It also keeps saturating stall and flush performance counters.
//
// Optional build macro: HAZ_WB_BYPASS_EN.
// When it is defined, the register file is write-before-read, so a WB-stage
// match does not stall. Only EX-stage matches stall.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RESET(0) | reset held; everything flushed, PC frozen
// RUN(1)   | normal issue; RAW hazards stall, a taken branch flushes
// FLUSH(2) | post-branch bubbles while instruction memory catches up
//
// FLUSH_CYCLES has a legal range of 1..3, which fits the 2-bit flush counter.

module pipeline_hazard_ctrl #(
   parameter int CNT_W        = 16,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [5:0]       rs_id,
   input  logic [5:0]       rt_id,
   input  logic             rs_used_id,
   input  logic             rt_used_id,
   input  logic [5:0]       rd_ex,
   input  logic             regWrt_ex,
   input  logic [5:0]       rd_wb,
   input  logic             regWrt_wb,
   input  logic             branch_taken_wb,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exwb_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [1:0]       flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   logic hz_ex, hz_wb, stall;
   logic stall_inc, flush_inc;

   // RAW detection: an ID source operand matches a pending destination.
   // Register 0 is an ordinary register here.
   always_comb begin
      hz_ex = regWrt_ex & ((rs_used_id & (rs_id == rd_ex)) |
                           (rt_used_id & (rt_id == rd_ex)));
      hz_wb = regWrt_wb & ((rs_used_id & (rs_id == rd_wb)) |
                           (rt_used_id & (rt_id == rd_wb)));
`ifdef HAZ_WB_BYPASS_EN
      stall = hz_ex;
`else
      stall = hz_ex | hz_wb;
`endif
   end

   // Next-state and pipeline control outputs; a taken branch outranks a stall.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exwb_flush  = 1'b1;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (branch_taken_wb) begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               flush_inc   = 1'b1;
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end else if (stall) begin
               ifid_flush  = 1'b0;
               exwb_flush  = 1'b0;
               stall_inc   = 1'b1;
            end else begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               ifid_flush  = 1'b0;
               idex_flush  = 1'b0;
               exwb_flush  = 1'b0;
            end
         end
         ST_FLUSH: begin
            // Only bubbles are in flight, so a branch arriving here is ignored.
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            exwb_flush = 1'b0;
            if (flush_cnt_q != 2'd0) begin
               flush_cnt_d = flush_cnt_q - 2'd1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            // RESET, and the unused encoding 3, both leave for RUN.
            state_d = ST_RUN;
         end
      endcase
   end

   // The performance counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (stall_inc && !(&stall_count_q)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
      if (flush_inc && !(&flush_count_q)) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   // State, flush counter and performance counters, with synchronous reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= ST_RESET;
         flush_cnt_q   <= 2'd0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // Drive the outputs directly from the registers.
   always_comb begin
      state       = state_q;
      stall_count = stall_count_q;
      flush_count = flush_count_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (CNT_W=4, FLUSH_CYCLES=2).
// A cycle model tracks the mode and the remaining flush bubbles.
// The outputs are compared against that model on every negative edge.
// Directed steps add literal expectations that pin the model.
// The bench honours HAZ_WB_BYPASS_EN if it is defined.

module tb_pipeline_hazard_ctrl;

   localparam int CNT_W  = 4;
   localparam int FLUSH_CYCLES = 2;
   localparam int SAT    = 15;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [5:0]       rs_id, rt_id, rd_ex, rd_wb;
   logic             rs_used_id, rt_used_id, regWrt_ex, regWrt_wb, branch_taken_wb;
   logic             pc_write, ifid_write, ifid_flush, idex_flush, exwb_flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count, flush_count;

   int errors = 0;
   int checks = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clock(clock), .reset_n(reset_n),
      .rs_id(rs_id), .rt_id(rt_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .rd_ex(rd_ex), .regWrt_ex(regWrt_ex), .rd_wb(rd_wb), .regWrt_wb(regWrt_wb),
      .branch_taken_wb(branch_taken_wb),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exwb_flush(exwb_flush),
      .state(state), .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 reset, 1 run, 2 flushing. m_left is the count of flush bubbles still owed.
   int m_mode = 0, m_left = 0, m_stalls = 0, m_flushes = 0;
   bit model_valid = 0;

   function automatic bit reads_reg(input logic [5:0] r);
      return (rs_used_id && rs_id == r) || (rt_used_id && rt_id == r);
   endfunction

   function automatic bit model_stall();
      bit ex_dep, wb_dep;
      ex_dep = regWrt_ex && reads_reg(rd_ex);
      wb_dep = regWrt_wb && reads_reg(rd_wb);
`ifdef HAZ_WB_BYPASS_EN
      wb_dep = 0;
`endif
      return ex_dep || wb_dep;
   endfunction

   // {pc_write, ifid_write, ifid_flush, idex_flush, exwb_flush}
   function automatic logic [4:0] model_ctrl();
      if (m_mode == 0) return 5'b00111;
      if (m_mode == 2) return 5'b11110;
      if (branch_taken_wb) return 5'b11111;
      if (model_stall()) return 5'b00010;
      return 5'b11000;
   endfunction

   always @(posedge clock) begin
      if (!reset_n) begin
         m_mode = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
         model_valid = 1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (branch_taken_wb) begin
            m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
            m_mode = 2;
            m_left = FLUSH_CYCLES;
         end else if (model_stall()) begin
            m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 0) m_mode = 1;
      end
   end

   // Compare every output against the model on each negative edge.
   always @(negedge clock) begin
      if (model_valid) begin
         logic [4:0] e;
         e = model_ctrl();
         chk("model_state", int'(state), m_mode);
         chk("model_ctrl", int'({pc_write, ifid_write, ifid_flush, idex_flush, exwb_flush}), int'(e));
         chk("model_stall_count", int'(stall_count), m_stalls);
         chk("model_flush_count", int'(flush_count), m_flushes);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rs_id = 6'd1; rt_id = 6'd2; rs_used_id = 1'b1; rt_used_id = 1'b1;
      rd_ex = 6'd10; regWrt_ex = 1'b0; rd_wb = 6'd11; regWrt_wb = 1'b0;
      branch_taken_wb = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      idle();
      reset_n = 1'b0;
      repeat (3) cyc();
      chk("rst_state", state, 0);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_flushes", {ifid_flush, idex_flush, exwb_flush}, 3'b111);
      reset_n = 1'b1;
      cyc();
      chk("run_state", state, 1);
      chk("run_pc_write", pc_write, 1);
      chk("run_flushes", {ifid_flush, idex_flush, exwb_flush}, 3'b000);

      // EX RAW on rs
      rd_ex = 6'd5; regWrt_ex = 1'b1; rs_id = 6'd5;
      #1;
      chk("ex_haz_ctrl", {pc_write, ifid_write, idex_flush}, 3'b001);
      cyc();
      chk("ex_haz_stall_count", stall_count, 1);
      idle();

      // rt matches EX but is an immediate
      rt_id = 6'd5; rt_used_id = 1'b0; rd_ex = 6'd5; regWrt_ex = 1'b1;
      #1;
      chk("unused_rt_pc_write", pc_write, 1);
      cyc();
      idle();

      // matching register but producer does not write
      rs_id = 6'd9; rd_ex = 6'd9; regWrt_ex = 1'b0;
      #1;
      chk("no_write_pc_write", pc_write, 1);
      cyc();
      idle();

      // WB match on rt
      rd_wb = 6'd7; regWrt_wb = 1'b1; rt_id = 6'd7;
      #1;
`ifdef HAZ_WB_BYPASS_EN
      chk("wb_match_pc_write", pc_write, 1);
`else
      chk("wb_match_pc_write", pc_write, 0);
`endif
      cyc();
      idle();

      // boundary registers 63 (EX, rt) and 0 (WB, rs)
      rt_id = 6'd63; rd_ex = 6'd63; regWrt_ex = 1'b1;
      #1;
      chk("reg63_pc_write", pc_write, 0);
      cyc();
      idle();
      rs_id = 6'd0; rd_wb = 6'd0; regWrt_wb = 1'b1;
      cyc();
      idle();
      cyc();
`ifdef HAZ_WB_BYPASS_EN
      chk("stall_total", stall_count, 2);
`else
      chk("stall_total", stall_count, 4);
`endif

      // taken branch together with an EX hazard, from a clean reset
      do_reset();
      rd_ex = 6'd5; regWrt_ex = 1'b1; rs_id = 6'd5; branch_taken_wb = 1'b1;
      #1;
      chk("br_ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, exwb_flush}, 5'b11111);
      cyc();
      chk("br_flush1_state", state, 2);
      chk("br_flush1_ifid_flush", ifid_flush, 1);
      chk("br_flush1_pc_write", pc_write, 1);
      cyc();
      chk("br_flush2_state", state, 2);
      cyc();
      idle();
      chk("br_back_state", state, 1);
      chk("br_flush_count", flush_count, 1);
      chk("br_stall_count", stall_count, 0);
      cyc();

      // reset asserted mid-FLUSH
      branch_taken_wb = 1'b1;
      cyc();
      branch_taken_wb = 1'b0;
      chk("mid_flush_state", state, 2);
      reset_n = 1'b0;
      cyc();
      chk("mid_flush_rst_state", state, 0);
      chk("mid_flush_rst_count", flush_count, 0);
      reset_n = 1'b1;
      cyc();
      chk("mid_flush_rel_state", state, 1);

      // saturation: 20 stall cycles
      rd_ex = 6'd3; regWrt_ex = 1'b1; rs_id = 6'd3;
      repeat (20) cyc();
      chk("sat_stall_count", stall_count, SAT);
      idle();
      cyc();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and flush controller for the 3-stage IF / ID / EX-WB pipeline. It watches register operands in ID and destination registers in EX and WB, and stalls the PC and IF/ID buffer on read-after-write hazards. When a branch or jump resolves taken in WB, it squashes the wrong-path work in the pipeline buffers. It also counts stall and flush cycles for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.
- FLUSH_CYCLES, 1, extra cycles after a taken branch during which IF/ID stays flushed, covering synchronous instruction-memory latency. Legal range is 1 to 3.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- rs_id  in  6  rs field of the instruction in ID.
- rt_id  in  6  rt field of the instruction in ID.
- rs_used_id  in  1  the ID instruction reads register rs (from decode).
- rt_used_id  in  1  the ID instruction reads register rt; 0 when rt is an immediate.
- rd_ex  in  6  destination register in EX.
- regWrt_ex  in  1  the EX instruction writes the register file.
- rd_wb  in  6  destination register in WB.
- regWrt_wb  in  1  the WB instruction writes the register file.
- branch_taken_wb  in  1  branchControl from WB (branchZero&z | branchNeg&n | jump).
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID buffer load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  clear ID/EX control bits (bubble).
- exwb_flush  out  1  clear EX/WB control bits.
- state  out  2  FSM state: 0 RESET, 1 RUN, 2 FLUSH.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flush events.

## Operation
FSM states:
- RESET: entered whenever reset_n=0. On the first edge with reset_n=1, go to RUN.
- RUN: normal issue. If branch_taken_wb=1, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
- FLUSH: hold while the flush counter is non-zero, decrementing it each cycle. When it reaches 0, go to RUN. A branch_taken_wb arriving in FLUSH is ignored, because only bubbles are in flight.

Hazard detection (combinational, RUN only):
- hz_ex = regWrt_ex & ((rs_used_id & rs_id==rd_ex) | (rt_used_id & rt_id==rd_ex)).
- hz_wb = the same expression using rd_wb and regWrt_wb.
- stall = hz_ex | hz_wb; with HAZ_WB_BYPASS_EN defined, stall = hz_ex only.
- All 64 register indices participate; there is no hardwired zero register.

Outputs by condition:
- RESET: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exwb_flush=1.
- RUN with a taken branch (takes priority over stall): pc_write=1 to load jumpAddress, ifid_write=1, ifid_flush=1, idex_flush=1, exwb_flush=1.
- RUN with stall: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, exwb_flush=0.
- RUN, otherwise: pc_write=1, ifid_write=1, all flushes 0.
- FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exwb_flush=0. No stall is evaluated in this state.

Counters:
- stall_count increments on every RUN cycle where stall=1 and branch_taken_wb=0.
- flush_count increments once per RUN→FLUSH transition.
- Both counters saturate at all-ones and reset to 0.

## Timing
- Reset values: state=0, both counters 0, and the flush counter 0. Combinational outputs take their RESET-state values while state=RESET. Reset asserted mid-FLUSH or mid-stall returns to RESET on the next edge.
- Hazard and flush outputs are combinational from the current inputs and state, so they take effect at the next rising edge. There is zero-cycle latency from hazard detection to stall.
- A stall lasts until the producer leaves EX/WB: at most 2 cycles without the bypass macro, at most 1 cycle with it.
- A taken branch costs 1 + FLUSH_CYCLES cycles of bubbles, counting from the WB cycle in which it resolves.
- A branch in WB while ID has a hazard is handled as a flush only: stall_count is unchanged and flush_count increments by 1.

## Configuration
- HAZ_WB_BYPASS_EN: when defined, the register file is treated as write-before-read, so a WB-stage match does not stall.
- When undefined, a WB match stalls for 1 cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release. Expect state=0, pc_write=0 and all flushes 1 during reset. On the first edge after release, state=1, pc_write=1 and all flushes 0.
- EX RAW hazard: rd_ex=5, regWrt_ex=1, rs_id=5, rs_used_id=1. Expect pc_write=0, ifid_write=0, idex_flush=1, and stall_count 0→1.
- Unused rt: rt_id=5, rt_used_id=0, rd_ex=5, regWrt_ex=1. Expect no stall.
- WB match: rd_wb=7, regWrt_wb=1, rt_id=7, rt_used_id=1. Without the macro, expect a 1-cycle stall. With HAZ_WB_BYPASS_EN defined, expect no stall.
- Taken branch with hazard: branch_taken_wb=1 together with an EX hazard. Expect pc_write=1 and all three flushes 1. Then state=2 for FLUSH_CYCLES cycles with ifid_flush=1, then state=1. flush_count=1 and stall_count unchanged. A second pulse during FLUSH is ignored.
- Saturation: with CNT_W=4, sustain 20 stall cycles. Expect stall_count to stop at 15.
